// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter/sequencer for MCB port 0.
// Port A carries CPU single-word reads/writes, port B carries fixed-length
// video burst reads. Requests are round-robined; the MCB command, write and
// read FIFOs are driven one transfer at a time.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | drop stray read words, otherwise arbitrate A/B
// A_WPUSH | push CPU write word into the write FIFO
// A_WCMD  | issue single-word write command
// A_RCMD  | issue single-word read command
// A_RWAIT | wait for the CPU read word, capture it
// B_CMD   | issue video burst read command
// B_DATA  | forward burst words to the video port
// ACK     | pulse a_ack for one cycle
module mem_arbiter #(
  parameter int VID_BURST = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        calib_done,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [29:0] a_addr,
  input  logic [31:0] a_wdata,
  input  logic [3:0]  a_mask,
  output logic        a_ack,
  output logic [31:0] a_rdata,
  input  logic        b_req,
  input  logic [29:0] b_addr,
  output logic        b_rvalid,
  output logic [31:0] b_rdata,
  output logic        b_ack,
  output logic        stray_rd,
  output logic        cmd_en,
  output logic [2:0]  cmd_instr,
  output logic [5:0]  cmd_bl,
  output logic [29:0] cmd_addr,
  input  logic        cmd_full,
  output logic        w_en,
  output logic [3:0]  w_mask,
  output logic [31:0] w_data,
  input  logic        w_full,
  output logic        r_en,
  input  logic [31:0] r_data,
  input  logic        r_empty
);

  typedef enum logic [2:0] {
    IDLE, A_WPUSH, A_WCMD, A_RCMD, A_RWAIT, B_CMD, B_DATA, ACK
  } state_t;

  localparam logic [5:0] B_BL  = 6'(VID_BURST - 1);
  localparam logic [6:0] B_LEN = 7'(VID_BURST);

  localparam logic [2:0] INSTR_WR = 3'b000;
  localparam logic [2:0] INSTR_RD = 3'b001;

  state_t      state;
  logic        last_grant_b;
  logic [29:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_mask;
  logic [6:0]  cnt;

  // Read FIFO pop: stray drop in IDLE, CPU word in A_RWAIT, burst words in B_DATA.
  always_comb begin
    r_en = 1'b0;
    if (!rst) begin
      case (state)
        IDLE, A_RWAIT, B_DATA: r_en = !r_empty;
        default:               r_en = 1'b0;
      endcase
    end
  end

  // Arbitration and transfer sequencing; all outputs besides r_en are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_grant_b <= 1'b1;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      lat_mask     <= '0;
      cnt          <= '0;
      a_ack        <= 1'b0;
      a_rdata      <= '0;
      b_rvalid     <= 1'b0;
      b_rdata      <= '0;
      b_ack        <= 1'b0;
      stray_rd     <= 1'b0;
      cmd_en       <= 1'b0;
      cmd_instr    <= '0;
      cmd_bl       <= '0;
      cmd_addr     <= '0;
      w_en         <= 1'b0;
      w_mask       <= '0;
      w_data       <= '0;
    end else begin
      cmd_en   <= 1'b0;
      w_en     <= 1'b0;
      a_ack    <= 1'b0;
      b_ack    <= 1'b0;
      b_rvalid <= 1'b0;
      stray_rd <= 1'b0;
      case (state)
        IDLE: begin
          if (!r_empty) begin
            stray_rd <= 1'b1;
          end else if (calib_done && !a_ack && !b_ack) begin
            // Acks are still visible during this cycle, so the finishing
            // requester has not yet dropped its req; skip arbitration.
            if (a_req && (!b_req || last_grant_b)) begin
              last_grant_b <= 1'b0;
              lat_addr     <= a_addr & ~30'h3;
              lat_wdata    <= a_wdata;
              lat_mask     <= a_mask;
              state        <= a_we ? A_WPUSH : A_RCMD;
            end else if (b_req) begin
              last_grant_b <= 1'b1;
              lat_addr     <= b_addr & ~30'h3;
              state        <= B_CMD;
            end
          end
        end
        A_WPUSH: begin
          if (!w_full) begin
            w_en   <= 1'b1;
            w_data <= lat_wdata;
            w_mask <= lat_mask;
            state  <= A_WCMD;
          end
        end
        A_WCMD: begin
          if (!cmd_full) begin
            cmd_en    <= 1'b1;
            cmd_instr <= INSTR_WR;
            cmd_bl    <= 6'd0;
            cmd_addr  <= lat_addr;
            state     <= ACK;
          end
        end
        A_RCMD: begin
          if (!cmd_full) begin
            cmd_en    <= 1'b1;
            cmd_instr <= INSTR_RD;
            cmd_bl    <= 6'd0;
            cmd_addr  <= lat_addr;
            state     <= A_RWAIT;
          end
        end
        A_RWAIT: begin
          if (!r_empty) begin
            a_rdata <= r_data;
            state   <= ACK;
          end
        end
        ACK: begin
          a_ack <= 1'b1;
          state <= IDLE;
        end
        B_CMD: begin
          if (!cmd_full) begin
            cmd_en    <= 1'b1;
            cmd_instr <= INSTR_RD;
            cmd_bl    <= B_BL;
            cmd_addr  <= lat_addr;
            cnt       <= B_LEN;
            state     <= B_DATA;
          end
        end
        B_DATA: begin
          if (!r_empty) begin
            b_rdata  <= r_data;
            b_rvalid <= 1'b1;
            cnt      <= cnt - 7'd1;
            if (cnt == 7'd1) begin
              b_ack <= 1'b1;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-port arbiter and sequencer for MCB port 0 of the LPDDR controller (s6_lpddr_ram).
- Port A: CPU single-word read/write.
- Port B: video fixed-length burst reads.
- Drives MCB command, write and read FIFOs; tracks calibration; round-robins between requesters.
- Sits between the CPU/video blocks and s6_lpddr_ram inside consolite.

Parameters:
VID_BURST, 16, words per video burst (1..64); cmd_bl = VID_BURST-1.

Ports:
clk  in  1  100MHz system clock
rst  in  1  synchronous active-high reset
calib_done  in  1  MCB calibration complete
a_req  in  1  CPU request; held with a_we/a_addr/a_wdata/a_mask until a_ack
a_we  in  1  1=write, 0=read
a_addr  in  30  byte address; bits[1:0] ignored
a_wdata  in  32  write data
a_mask  in  4  write byte mask, 1=byte not written (MCB convention)
a_ack  out  1  one-cycle completion pulse
a_rdata  out  32  read data, valid when a_ack follows a read
b_req  in  1  video burst request; held with b_addr until b_ack
b_addr  in  30  burst start byte address; bits[1:0] ignored
b_rvalid  out  1  one-cycle pulse per burst word
b_rdata  out  32  burst word, valid with b_rvalid
b_ack  out  1  pulse coincident with final b_rvalid
stray_rd  out  1  pulse when an unexpected read word is discarded
cmd_en  out  1  MCB p0 cmd_en
cmd_instr  out  3  000=write, 001=read
cmd_bl  out  6  burst length minus 1
cmd_addr  out  30  byte address, bits[1:0]=00
cmd_full  in  1  MCB command FIFO full
w_en  out  1  MCB write FIFO push
w_mask  out  4  write mask
w_data  out  32  write data
w_full  in  1  MCB write FIFO full
r_en  out  1  MCB read FIFO pop (combinational)
r_data  in  32  read FIFO head; valid while !r_empty
r_empty  in  1  read FIFO empty

Behaviour:
- All outputs except r_en are registered.
- Reset (any cycle, including mid-burst): state=IDLE; all outputs 0; last_grant=B, so A wins the first tie.
- rst is applied together with the MCB reset. Read words arriving after an aborted burst fall under the stray rule.

States: IDLE, A_WPUSH, A_WCMD, A_RCMD, A_RWAIT, B_CMD, B_DATA, ACK.

IDLE:
- No grant while calib_done=0.
- If !r_empty: r_en=1, word dropped, stray_rd pulses next cycle. No grant that cycle.
- Otherwise grant selection:
  - Only one req: grant it.
  - Both: grant the one not in last_grant.
- On grant: latch address/data/mask (address low 2 bits forced 0) and update last_grant.
- Next state: A write→A_WPUSH, A read→A_RCMD, B→B_CMD.

A_WPUSH:
- Wait while w_full.
- Else w_en=1 for one cycle with w_data/w_mask → A_WCMD.

A_WCMD:
- Wait while cmd_full.
- Else cmd_en=1, cmd_instr=000, cmd_bl=0 → ACK.

A_RCMD:
- Same as A_WCMD, with cmd_instr=001 → A_RWAIT.

A_RWAIT:
- When !r_empty: r_en=1, a_rdata<=r_data → ACK.

ACK:
- Grantee's ack high this one cycle → IDLE.
- Requester drops req the cycle after ack; IDLE does not sample req during ACK.
- Write latency with FIFOs free: grant edge +3 cycles to a_ack.

B_CMD:
- Wait while cmd_full.
- Else cmd_en=1, cmd_instr=001, cmd_bl=VID_BURST-1; load cnt=VID_BURST → B_DATA.

B_DATA:
- Each cycle with !r_empty: r_en=1, b_rdata<=r_data, b_rvalid=1 next cycle, cnt-1.
- Gaps when r_empty are allowed.
- On the pop with cnt=1: b_ack pulses with that word's b_rvalid → IDLE.

Other rules:
- cmd_en, w_en and r_en are never high for more than one cycle per transfer.
- calib_done falling mid-transaction does not abort it; it only blocks new grants.
- Requests are never dropped. A requester held off by a tie wins the next arbitration.

Test Plan:
1. calib_done=0, a_req write addr 0x10 → no cmd_en. Raise calib_done → w_en (w_data=a_wdata, mask 0000), then cmd_en instr 000 bl 0 addr 0x10, then a_ack 1 cycle; total 3 cycles after grant.
2. A read addr 0x7 → cmd_addr 0x4, instr 001. Model returns 0xDEADBEEF after 5 cycles → r_en 1 cycle, a_ack with a_rdata=0xDEADBEEF.
3. VID_BURST=16, b_req addr 0x1000 → cmd_bl=15. Model supplies 16 words with random r_empty gaps → exactly 16 b_rvalid pulses in order; b_ack on the 16th only.
4. a_req and b_req asserted continuously from reset → grants alternate A,B,A,B; neither starves.
5. cmd_full and w_full held high 10 cycles during an A write → no cmd_en/w_en until released; then normal completion.
6. Stray word in read FIFO while IDLE → r_en, stray_rd pulse, no ack. Separately, rst mid-burst after 4 of 16 words → all outputs 0 next cycle, state IDLE.
